// File: rtl/clock_timebase_pkg.sv
// rtl/clock_timebase_pkg.sv - shared constants, mode encoding and seconds helper for the timebase
package clock_pkg;

    localparam int DAY_SECONDS  = 86400;
    localparam int SEC_PER_HOUR = 3600;
    localparam int SEC_PER_MIN  = 60;
    localparam int COUNT_W      = 21;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } mode_e;

    // Fields are widened before multiplying so the product cannot truncate.
    function automatic logic [COUNT_W-1:0] to_seconds(input logic [4:0] hh,
                                                      input logic [5:0] mm,
                                                      input logic [5:0] ss);
        return COUNT_W'(hh) * COUNT_W'(SEC_PER_HOUR)
             + COUNT_W'(mm) * COUNT_W'(SEC_PER_MIN)
             + COUNT_W'(ss);
    endfunction

endpackage

// File: rtl/clock_timebase_if.sv
// rtl/clock_timebase_if.sv - key inputs and time/alarm outputs of the timebase
interface clock_timebase_if;
    import clock_pkg::*;

    logic               key_mode;
    logic               key_inc;
    logic               clk_1hz;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_alarm;
    logic [2:0]         mode;

    modport master (
        output key_mode, key_inc,
        input  clk_1hz, count, count_alarm, mode
    );

    modport slave (
        input  key_mode, key_inc,
        output clk_1hz, count, count_alarm, mode
    );

endinterface

// File: rtl/clock_timebase_tick_divider.sv
// rtl/clock_timebase_tick_divider.sv - divides clk into a once-per-second tick and a 50% clk_1hz
module tick_divider #(
    parameter int CLK_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic clk_1hz
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_HZ / 2);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_MAX);

    // clk_1hz trails div by one cycle so it rises just after the second boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            clk_1hz <= 1'b1;
        end else begin
            if (clr || tick) begin
                div <= '0;
            end else begin
                div <= div + DIV_W'(1);
            end
            clk_1hz <= (div < DIV_HALF);
        end
    end

endmodule

// File: rtl/clock_timebase.sv
// rtl/clock_timebase.sv - time-of-day and alarm registers with two-key setting FSM
module clock_timebase
    import clock_pkg::*;
#(
    parameter int CLK_HZ      = 1000,
    parameter int ALARM_RST_H = 7
) (
    input  logic             clk,
    input  logic             rst,
    clock_timebase_if.slave  bus
);

    mode_e state_q, state_d;

    logic tick;
    logic time_run;
    logic enter_set_h;
    logic div_clr;
    logic inc_h, inc_m, inc_ah, inc_am;

    logic [4:0] h, ah;
    logic [5:0] m, s, am;

    logic [COUNT_W-1:0] count_q, count_alarm_q;

    tick_divider #(.CLK_HZ(CLK_HZ)) u_div (
        .clk     (clk),
        .rst     (rst),
        .clr     (div_clr),
        .tick    (tick),
        .clk_1hz (bus.clk_1hz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.key_mode) state_d = SET_H;
            SET_H:   if (bus.key_mode) state_d = SET_M;
            SET_M:   if (bus.key_mode) state_d = SET_AH;
            SET_AH:  if (bus.key_mode) state_d = SET_AM;
            SET_AM:  if (bus.key_mode) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // A mode key in the same cycle as an inc key swallows the inc.
    always_comb begin
        time_run    = (state_q == RUN) || (state_q == SET_AH) || (state_q == SET_AM);
        enter_set_h = 1'b0;
        div_clr     = 1'b0;
        inc_h       = 1'b0;
        inc_m       = 1'b0;
        inc_ah      = 1'b0;
        inc_am      = 1'b0;
        if (bus.key_mode) begin
            enter_set_h = (state_q == RUN);
            div_clr     = (state_q == SET_M);
        end else if (bus.key_inc) begin
            case (state_q)
                SET_H:   inc_h  = 1'b1;
                SET_M:   inc_m  = 1'b1;
                SET_AH:  inc_ah = 1'b1;
                SET_AM:  inc_am = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            m <= '0;
            s <= '0;
        end else begin
            if (tick && time_run) begin
                if (s == 6'd59) begin
                    s <= '0;
                    if (m == 6'd59) begin
                        m <= '0;
                        h <= (h == 5'd23) ? 5'd0 : h + 5'd1;
                    end else begin
                        m <= m + 6'd1;
                    end
                end else begin
                    s <= s + 6'd1;
                end
            end
            // Time is frozen in SET_H/SET_M, so these never race the carry chain.
            if (inc_h) h <= (h == 5'd23) ? 5'd0 : h + 5'd1;
            if (inc_m) m <= (m == 6'd59) ? 6'd0 : m + 6'd1;
            if (enter_set_h) s <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ah <= 5'(ALARM_RST_H);
            am <= '0;
        end else begin
            if (inc_ah) ah <= (ah == 5'd23) ? 5'd0 : ah + 5'd1;
            if (inc_am) am <= (am == 6'd59) ? 6'd0 : am + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q       <= '0;
            count_alarm_q <= to_seconds(5'(ALARM_RST_H), 6'd0, 6'd0);
        end else begin
            count_q       <= to_seconds(h, m, s);
            count_alarm_q <= to_seconds(ah, am, 6'd0);
        end
    end

    assign bus.count       = count_q;
    assign bus.count_alarm = count_alarm_q;
    assign bus.mode        = state_q;

endmodule
